// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and its address/write-enable generator.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled on s_tick, with start/receiving/over handshake.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit to confirm it
// DATA  | sampling payload bits at mid-bit, LSB first
// STOP  | sampling stop bit at mid-bit
// BREAK | stop bit was low; wait for line to return high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 s_tick,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 recieve_start,
    output logic                 recieving,
    output logic                 recieve_over,
    output logic                 frame_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 start_n, recv_n, over_n, ferr_n;

    uart_rx_sync u_sync (
        .clk   (s_tick),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge s_tick) begin
        if (!rst_n) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data_out      <= '0;
            recieve_start <= 1'b0;
            recieving     <= 1'b0;
            recieve_over  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_idx       <= bit_n;
            shreg         <= shreg_n;
            data_out      <= data_n;
            recieve_start <= start_n;
            recieving     <= recv_n;
            recieve_over  <= over_n;
            frame_error   <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data_out;
        start_n = 1'b0;
        recv_n  = recieving;
        over_n  = recieve_over;
        ferr_n  = frame_error;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end

            START: begin
                if (tick_cnt == HALF_M1) begin
                    if (!rx_s) begin
                        start_n = 1'b1;
                        recv_n  = 1'b1;
                        over_n  = 1'b0;
                        ferr_n  = 1'b0;
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end

            DATA: begin
                if (tick_cnt == FULL_M1) begin
                    tick_n  = '0;
                    bit_n   = bit_idx + BW'(1);
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        data_n  = shreg_n;
                        recv_n  = 1'b0;
                        state_n = STOP;
                    end
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end

            STOP: begin
                if (tick_cnt == FULL_M1) begin
                    tick_n = '0;
                    over_n = 1'b1;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end

            BREAK: begin
                // A held-low line must not be mistaken for a new start bit.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scenario tasks plus a scoreboard monitor.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int OS = 16;
    localparam int NB = 8;

    logic          s_tick = 1'b0;
    logic          rst_n  = 1'b0;
    logic          rx     = 1'b1;
    logic [NB-1:0] data_out;
    logic          recieve_start;
    logic          recieving;
    logic          recieve_over;
    logic          frame_error;

    int asserts  = 0;
    int failures = 0;
    int start_cnt = 0;
    int over_cnt  = 0;

    logic [NB-1:0] exp_data[$];
    logic          exp_ferr[$];

    always #5 s_tick = ~s_tick;

    uart_receiver dut (
        .s_tick        (s_tick),
        .rst_n         (rst_n),
        .rx            (rx),
        .data_out      (data_out),
        .recieve_start (recieve_start),
        .recieving     (recieving),
        .recieve_over  (recieve_over),
        .frame_error   (frame_error)
    );

    task automatic align();
        @(posedge s_tick);
        #2;
    endtask

    // Caller must be aligned at posedge+2; leaves rx at the stop value.
    task automatic send_frame(input logic [NB-1:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (OS) @(posedge s_tick);
        #2;
        for (int i = 0; i < NB; i++) begin
            rx = b[i];
            repeat (OS) @(posedge s_tick);
            #2;
        end
        rx = stop_bit;
        repeat (OS) @(posedge s_tick);
        #2;
    endtask

    task automatic monitor();
        logic prev_recv = 1'b0;
        logic prev_over = 1'b0;
        logic armed     = 1'b0;
        int   high_len  = 0;
        int   gap       = 0;
        forever begin
            @(negedge s_tick);
            if (rst_n !== 1'b1) begin
                prev_recv = 1'b0;
                prev_over = 1'b0;
                armed     = 1'b0;
                high_len  = 0;
                gap       = 0;
            end else begin
                if (recieve_start === 1'b1) begin
                    start_cnt++;
                    asserts++;
                    if (recieve_over !== 1'b0) begin
                        failures++;
                        $display("FAIL start_over_overlap: recieve_over=%b required 0", recieve_over);
                    end
                end
                if (recieving === 1'b1) high_len++;
                if (armed) gap++;
                if (prev_recv && recieving === 1'b0) begin
                    asserts += 2;
                    if (high_len != NB * OS) begin
                        failures++;
                        $display("FAIL recieving_len: %0d cycles required %0d", high_len, NB * OS);
                    end
                    if (exp_data.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: data_out=%h with no expected byte", data_out);
                    end else if (data_out !== exp_data[0]) begin
                        failures++;
                        $display("FAIL sb_data: data_out=%h required %h", data_out, exp_data[0]);
                    end
                    high_len = 0;
                    gap      = 0;
                    armed    = 1'b1;
                end
                if (!prev_over && recieve_over === 1'b1) begin
                    over_cnt++;
                    asserts += 2;
                    if (!armed || gap != OS) begin
                        failures++;
                        $display("FAIL over_delay: %0d cycles (armed=%b) required %0d", gap, armed, OS);
                    end
                    if (exp_ferr.size() == 0) begin
                        failures++;
                        $display("FAIL sb_over_unexpected: recieve_over rose with empty scoreboard");
                    end else begin
                        if (frame_error !== exp_ferr[0]) begin
                            failures++;
                            $display("FAIL sb_ferr: frame_error=%b required %b", frame_error, exp_ferr[0]);
                        end
                        void'(exp_data.pop_front());
                        void'(exp_ferr.pop_front());
                    end
                    armed = 1'b0;
                end
                prev_recv = (recieving === 1'b1);
                prev_over = (recieve_over === 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (5) @(posedge s_tick);
        #2;
        rst_n = 1'b1;
        rx    = 1'b1;
        @(negedge s_tick);
        asserts += 5;
        if (data_out !== 8'h00)      begin failures++; $display("FAIL rst_data: %h required 00", data_out); end
        if (recieve_start !== 1'b0)  begin failures++; $display("FAIL rst_start: %b required 0", recieve_start); end
        if (recieving !== 1'b0)      begin failures++; $display("FAIL rst_recv: %b required 0", recieving); end
        if (recieve_over !== 1'b0)   begin failures++; $display("FAIL rst_over: %b required 0", recieve_over); end
        if (frame_error !== 1'b0)    begin failures++; $display("FAIL rst_ferr: %b required 0", frame_error); end
        repeat (20) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 2;
        if (dut.state !== IDLE) begin failures++; $display("FAIL rst_state: %0d required IDLE", dut.state); end
        if (start_cnt !== 0)    begin failures++; $display("FAIL rst_no_start: %0d starts required 0", start_cnt); end
    endtask

    task automatic test_single_frame();
        int   lat;
        logic hit;
        int   base;
        align();
        base = start_cnt;
        exp_data.push_back(8'hA5);
        exp_ferr.push_back(1'b0);
        lat = 0;
        hit = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge s_tick);
                while (!hit && lat < 40) begin
                    @(posedge s_tick);
                    lat++;
                    @(negedge s_tick);
                    if (recieve_start === 1'b1) hit = 1'b1;
                end
            end
        join
        repeat (20) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 5;
        if (!hit || lat != 10)        begin failures++; $display("FAIL start_latency: %0d (hit=%b) required 10", lat, hit); end
        if (start_cnt != base + 1)    begin failures++; $display("FAIL a5_starts: %0d required %0d", start_cnt, base + 1); end
        if (data_out !== 8'hA5)       begin failures++; $display("FAIL a5_data: %h required a5", data_out); end
        if (recieve_over !== 1'b1)    begin failures++; $display("FAIL a5_over: %b required 1", recieve_over); end
        if (frame_error !== 1'b0)     begin failures++; $display("FAIL a5_ferr: %b required 0", frame_error); end
    endtask

    task automatic test_glitch();
        logic [NB-1:0] d0;
        int            base;
        align();
        d0   = data_out;
        base = start_cnt;
        rx   = 1'b0;
        repeat (5) @(posedge s_tick);
        #2;
        rx = 1'b1;
        repeat (30) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 4;
        if (start_cnt != base)     begin failures++; $display("FAIL glitch_start: %0d required %0d", start_cnt, base); end
        if (data_out !== d0)       begin failures++; $display("FAIL glitch_data: %h required %h", data_out, d0); end
        if (dut.state !== IDLE)    begin failures++; $display("FAIL glitch_state: %0d required IDLE", dut.state); end
        if (recieve_over !== 1'b1) begin failures++; $display("FAIL glitch_over: %b required 1", recieve_over); end
    endtask

    task automatic test_frame_error();
        int base;
        align();
        base = start_cnt;
        exp_data.push_back(8'h3C);
        exp_ferr.push_back(1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge s_tick);
        @(negedge s_tick);
        asserts++;
        if (start_cnt != base + 1) begin failures++; $display("FAIL break_start: %0d required %0d", start_cnt, base + 1); end
        align();
        rx = 1'b1;
        repeat (10) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 4;
        if (data_out !== 8'h3C)    begin failures++; $display("FAIL ferr_data: %h required 3c", data_out); end
        if (recieve_over !== 1'b1) begin failures++; $display("FAIL ferr_over: %b required 1", recieve_over); end
        if (frame_error !== 1'b1)  begin failures++; $display("FAIL ferr_flag: %b required 1", frame_error); end
        if (dut.state !== IDLE)    begin failures++; $display("FAIL ferr_state: %0d required IDLE", dut.state); end
        align();
        exp_data.push_back(8'h81);
        exp_ferr.push_back(1'b0);
        send_frame(8'h81, 1'b1);
        repeat (20) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 3;
        if (data_out !== 8'h81)    begin failures++; $display("FAIL ok_data: %h required 81", data_out); end
        if (frame_error !== 1'b0)  begin failures++; $display("FAIL ferr_clear: %b required 0", frame_error); end
        if (start_cnt != base + 2) begin failures++; $display("FAIL ferr_starts: %0d required %0d", start_cnt, base + 2); end
    endtask

    task automatic test_back_to_back();
        int base_s;
        int base_o;
        align();
        base_s = start_cnt;
        base_o = over_cnt;
        for (int i = 0; i < 26; i++) begin
            exp_data.push_back(NB'(i));
            exp_ferr.push_back(1'b0);
            send_frame(NB'(i), 1'b1);
        end
        repeat (30) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 3;
        if (start_cnt - base_s != 26) begin failures++; $display("FAIL b2b_starts: %0d required 26", start_cnt - base_s); end
        if (over_cnt - base_o != 26)  begin failures++; $display("FAIL b2b_overs: %0d required 26", over_cnt - base_o); end
        if (exp_data.size() != 0)     begin failures++; $display("FAIL b2b_dropped: %0d left required 0", exp_data.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int base_o;
        align();
        base_o = over_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (OS * 5 + 8) @(posedge s_tick);
                #2;
                rst_n = 1'b0;
                @(posedge s_tick);
                @(negedge s_tick);
                asserts += 6;
                if (data_out !== 8'h00)     begin failures++; $display("FAIL mid_rst_data: %h required 00", data_out); end
                if (recieve_start !== 1'b0) begin failures++; $display("FAIL mid_rst_start: %b required 0", recieve_start); end
                if (recieving !== 1'b0)     begin failures++; $display("FAIL mid_rst_recv: %b required 0", recieving); end
                if (recieve_over !== 1'b0)  begin failures++; $display("FAIL mid_rst_over: %b required 0", recieve_over); end
                if (frame_error !== 1'b0)   begin failures++; $display("FAIL mid_rst_ferr: %b required 0", frame_error); end
                if (dut.state !== IDLE)     begin failures++; $display("FAIL mid_rst_state: %0d required IDLE", dut.state); end
                @(posedge s_tick);
                #2;
                rst_n = 1'b1;
            end
        join
        repeat (30) @(posedge s_tick);
        @(negedge s_tick);
        asserts++;
        if (over_cnt != base_o) begin failures++; $display("FAIL mid_rst_no_over: %0d required %0d", over_cnt, base_o); end
        align();
        exp_data.push_back(8'h55);
        exp_ferr.push_back(1'b0);
        send_frame(8'h55, 1'b1);
        repeat (20) @(posedge s_tick);
        @(negedge s_tick);
        asserts += 3;
        if (data_out !== 8'h55)    begin failures++; $display("FAIL post_rst_data: %h required 55", data_out); end
        if (recieve_over !== 1'b1) begin failures++; $display("FAIL post_rst_over: %b required 1", recieve_over); end
        if (exp_data.size() != 0)  begin failures++; $display("FAIL post_rst_sb: %0d left required 0", exp_data.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive front end of the image down-sampler's UART path. It oversamples the `rx` line 16× on `s_tick`, de-serialises 8N1 frames LSB-first and presents each byte on `data_out`. It drives the `recieve_start` / `recieving` / `recieve_over` handshake consumed by the downstream UART address/write-enable generator, which commits each byte to image memory. Frames with a bad stop bit are flagged.

## Interface
- `OVERSAMPLE`, default 16: `s_tick` cycles per bit; must be even and ≥ 4.
- `DATA_BITS`, default 8: payload bits per frame.
- `s_tick` input 1: sole clock, 16× baud oversample tick; all logic on its rising edge.
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `data_out` output `DATA_BITS`: last received byte; valid from the falling edge of `recieving` until the next start is confirmed.
- `recieve_start` output 1: single-cycle pulse when a start bit is confirmed.
- `recieving` output 1: high from start confirmation until the last data bit is sampled.
- `recieve_over` output 1: level; set at stop-bit sample, cleared at the next start confirmation.
- `frame_error` output 1: level; set when the stop bit samples 0, cleared at the next start confirmation.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`, reset to 1. All decisions use `rx_s`.
- Internal state: `tick_cnt` (log2 `OVERSAMPLE` bits), `bit_idx` (log2 `DATA_BITS` bits), and shift register `shreg`.
- FSM states:
  - **IDLE**: if `rx_s`=0, go to START with `tick_cnt`=0.
  - **START**: increment `tick_cnt`. When `tick_cnt`=`OVERSAMPLE`/2−1:
    - if `rx_s`=0: pulse `recieve_start`; set `recieving`=1; clear `recieve_over` and `frame_error`; set `tick_cnt`=0 and `bit_idx`=0; go to DATA.
    - otherwise it is a glitch: go to IDLE with no outputs changed.
  - **DATA**: at `tick_cnt`=`OVERSAMPLE`−1, shift `rx_s` into the MSB of `shreg` (so the byte ends up LSB-first), set `tick_cnt`=0, and increment `bit_idx`. On the sample where `bit_idx`=`DATA_BITS`−1: `data_out` ← completed byte, `recieving`=0, go to STOP.
  - **STOP**: at `tick_cnt`=`OVERSAMPLE`−1, set `recieve_over`=1.
    - if `rx_s`=1: go to IDLE.
    - otherwise: set `frame_error`=1 and go to BREAK.
  - **BREAK**: wait for `rx_s`=1, then go to IDLE. No start bit is accepted while the line is held low.
- `data_out` is never modified outside the final DATA sample, so a byte with a bad stop bit is still presented. The consumer decides whether to keep it.
- A `rst_n` assertion mid-frame aborts the frame. The FSM goes to IDLE and the partial byte is discarded.

## Timing
- Reset values:
  - `data_out`=0, `recieve_start`=0, `recieving`=0, `recieve_over`=0, `frame_error`=0.
  - State=IDLE, `rx_s` and synchroniser flops = 1.
- Falling start edge at `rx` → `recieve_start` after 2 (sync) + `OVERSAMPLE`/2 cycles = 10 with defaults.
- `recieving` high for `DATA_BITS`·`OVERSAMPLE` cycles = 128. It falls in the same cycle `data_out` updates.
- `recieve_over` rises `OVERSAMPLE` cycles after `recieving` falls. The consumer has those 16 cycles to write the byte.
- `recieve_start` and `recieve_over` never rise in the same cycle. `recieve_over`=0 in the cycle `recieve_start` pulses.
- Back-to-back frames: the next start edge is accepted in the first cycle after returning to IDLE, i.e. a half-bit into the stop bit.
- Frame period 10 bits = 160 cycles; sustained throughput is one byte per 160 `s_tick`.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - Defaults for `OVERSAMPLE`/`DATA_BITS`; the address generator imports the same package.
- One sub-module: `uart_rx_sync`, a 2-flop synchroniser with reset value 1.
- FSM, counters and shift register live in `uart_receiver`.

## Test plan
- Reset held 5 cycles with `rx`=0, then release with `rx`=1 → all outputs 0, FSM in IDLE, no `recieve_start`.
- Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) → `recieve_start` pulse at cycle 10; `recieving` high 128 cycles; `data_out`=0xA5 when it falls; `recieve_over`=1 16 cycles later; `frame_error`=0.
- 5-cycle low glitch on idle line → no `recieve_start`; FSM returns to IDLE; `data_out` unchanged.
- Frame 0x3C with stop bit 0, line held low 40 cycles then high, then frame 0x81 → after first frame `data_out`=0x3C, `recieve_over`=1, `frame_error`=1; no start accepted during the low period; second frame gives `data_out`=0x81 and clears `frame_error`.
- 26 back-to-back frames 0x00..0x19 at 160-cycle spacing → 26 `recieve_start` pulses; each `data_out` is correct; `recieve_over` cycles low→high each frame; no frame is dropped.
- `rst_n` asserted at bit 4 of a 0xFF frame → outputs are reset values next cycle; `recieve_over` never asserts; the next clean frame 0x55 is received correctly.
